multiexp_fp2_feeder: RTL

- Upstream feeder for the G2 (Fp2) multiexp core.
- Buffers NUM_IN scalar/point records in on-chip RAM, then replays them as the looping 7-beat stream the core consumes: scalar first, then 6 point words.
- Replays KEY_BITS passes. On each pass the scalar is pre-shifted, so the key bit under test is always at bit KEY_BITS-1.
- Memory is retained after a run, so the same record set can be replayed without reloading.

---
 rtl/multiexp_fp2_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multiexp_fp2_feeder.sv
// multiexp_fp2_feeder: buffers scalar/point records in RAM and replays them KEY_BITS times as 7-beat streams with a pre-shifted scalar.
module multiexp_fp2_feeder #(
  parameter int DAT_BITS = 381,
  parameter int KEY_BITS = 256,
  parameter int CTL_BITS = 16,
  parameter int MAX_IN   = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ld_val,
  input  logic                         i_ld_sop,
  input  logic                         i_ld_eop,
  input  logic [DAT_BITS-1:0]          i_ld_dat,
  output logic                         o_ld_rdy,
  output logic                         o_pnt_scl_val,
  output logic                         o_pnt_scl_sop,
  output logic                         o_pnt_scl_eop,
  output logic [DAT_BITS-1:0]          o_pnt_scl_dat,
  output logic [CTL_BITS-1:0]          o_pnt_scl_ctl,
  input  logic                         i_pnt_scl_rdy,
  input  logic [$clog2(MAX_IN):0]      i_num_in,
  input  logic                         i_start,
  output logic [$clog2(MAX_IN):0]      o_loaded,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);
  localparam int LW = $clog2(MAX_IN) + 1;
  localparam int AW = $clog2(7 * MAX_IN);
  localparam int PW = KEY_BITS > 1 ? $clog2(KEY_BITS) : 1;
  localparam int EW = DAT_BITS + 3;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t r_state, w_next;
  logic [DAT_BITS-1:0] r_ram [0:7*MAX_IN-1];
  logic [DAT_BITS-1:0] r_q, w_sh;
  logic [LW-1:0] r_loaded, r_num, r_ir, w_rec;
  logic [PW-1:0] r_ip, r_qp;
  logic [2:0] r_lb, r_ib, r_qb, w_wbeat, w_occ;
  logic [1:0] r_cnt, w_slot;
  logic [EW-1:0] r_f0, r_f1, w_f0n, w_f1n, w_new;
  logic [AW-1:0] w_waddr, w_raddr;
  logic r_clr, r_qv, r_ql, r_iss_done, r_done, r_err;
  logic w_ld_acc, w_legal, w_pop, w_last_pop, w_issue, w_issue_last, w_we;
  assign o_ld_rdy = ~i_rst & ((r_state == IDLE & ~i_start) | r_state == LOAD);
  assign w_ld_acc = i_ld_val & o_ld_rdy;
  assign w_legal = i_num_in != '0 && i_num_in <= r_loaded;
  assign o_pnt_scl_val = r_cnt != 2'd0;
  assign o_pnt_scl_sop = r_f0[DAT_BITS+1];
  assign o_pnt_scl_eop = r_f0[DAT_BITS];
  assign o_pnt_scl_dat = r_f0[DAT_BITS-1:0];
  assign o_pnt_scl_ctl = '0;
  assign o_busy = r_state == STREAM;
  assign o_loaded = r_loaded;
  assign o_done = r_done;
  assign o_err = r_err;
  assign w_pop = o_pnt_scl_val & i_pnt_scl_rdy;
  assign w_last_pop = w_pop & r_f0[EW-1];
  // A record written from IDLE after a completed run restarts the record set at index 0
  assign w_rec = (r_state == IDLE && r_clr) ? '0 : r_loaded;
  assign w_wbeat = i_ld_sop ? 3'd0 : r_lb;
  assign w_we = w_ld_acc && (i_ld_sop || r_state == LOAD) && w_rec < LW'(MAX_IN);
  assign w_waddr = AW'(w_rec) * AW'(7) + AW'(w_wbeat);
  assign w_raddr = AW'(r_ir) * AW'(7) + AW'(r_ib);
  assign w_issue_last = r_ip == PW'(KEY_BITS - 1) && r_ir == r_num - LW'(1) && r_ib == 3'd6;
  // Issue a read only if the result is guaranteed a free skid slot when it lands
  assign w_occ = 3'(r_cnt) + 3'(r_qv) - 3'(w_pop);
  assign w_issue = r_state == STREAM && !r_iss_done && w_occ < 3'd2;
  assign w_slot = r_cnt - 2'(w_pop);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? (w_legal ? STREAM : IDLE) : (w_ld_acc && i_ld_sop ? LOAD : IDLE);
      LOAD:    w_next = (w_ld_acc && i_ld_eop && !i_ld_sop) ? IDLE : LOAD;
      STREAM:  w_next = w_last_pop ? IDLE : STREAM;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_sh = '0;
    w_sh[KEY_BITS-1:0] = r_q[KEY_BITS-1:0] << r_qp;
    w_new = {r_ql, r_qb == 3'd0, r_qb == 3'd6, r_qb == 3'd0 ? w_sh : r_q};
    w_f0n = w_pop ? r_f1 : r_f0;
    w_f1n = r_f1;
    if (r_qv && w_slot == 2'd0) w_f0n = w_new;
    if (r_qv && w_slot != 2'd0) w_f1n = w_new;
  end
  always_ff @(posedge i_clk) begin
    if (w_we) r_ram[w_waddr] <= i_ld_dat;
    r_q <= r_ram[w_raddr];
  end
  always_ff @(posedge i_clk)
    r_state <= i_rst ? IDLE : w_next;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_loaded <= '0; r_num <= '0; r_ir <= '0; r_ip <= '0; r_qp <= '0;
      r_lb <= '0; r_ib <= '0; r_qb <= '0; r_cnt <= '0; r_f0 <= '0; r_f1 <= '0;
      r_clr <= 1'b0; r_qv <= 1'b0; r_ql <= 1'b0; r_iss_done <= 1'b0;
      r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err <= 1'b0;
      if (r_state == IDLE && i_start) begin
        if (w_legal) begin
          r_num <= i_num_in;
          r_ip <= '0; r_ir <= '0; r_ib <= '0;
          r_iss_done <= 1'b0;
        end else r_err <= 1'b1;
      end
      if (w_ld_acc && i_ld_sop) begin
        r_lb <= 3'd1;
        if (r_state == IDLE && r_clr) begin
          r_loaded <= '0;
          r_clr <= 1'b0;
        end
      end else if (w_ld_acc && r_state == LOAD) begin
        r_lb <= (i_ld_eop || r_lb == 3'd6) ? 3'd0 : r_lb + 3'd1;
        if (i_ld_eop && r_lb == 3'd6 && r_loaded < LW'(MAX_IN)) r_loaded <= r_loaded + LW'(1);
      end
      r_qv <= w_issue;
      if (w_issue) begin
        r_qp <= r_ip; r_qb <= r_ib; r_ql <= w_issue_last;
        r_iss_done <= w_issue_last;
        r_ib <= r_ib == 3'd6 ? 3'd0 : r_ib + 3'd1;
        if (r_ib == 3'd6) r_ir <= r_ir == r_num - LW'(1) ? '0 : r_ir + LW'(1);
        if (r_ib == 3'd6 && r_ir == r_num - LW'(1)) r_ip <= r_ip + PW'(1);
      end
      r_cnt <= r_cnt + 2'(r_qv) - 2'(w_pop);
      r_f0 <= w_f0n;
      r_f1 <= w_f1n;
      if (w_last_pop) begin
        r_done <= 1'b1;
        r_clr <= 1'b1;
      end
    end
  end
endmodule
